// File: rtl/trace_regs_pkg.sv
// Shared constants for the trace event register block: register map, CTRL/STATUS
// bit positions, sentinel values and FIFO entry layout.
package trace_regs_pkg;

  localparam int ADDR_W = 14;

  localparam logic [13:0] ADDR_CTRL      = 14'h0000;
  localparam logic [13:0] ADDR_STATUS    = 14'h0001;
  localparam logic [13:0] ADDR_TIMESTAMP = 14'h0002;
  localparam logic [13:0] ADDR_FIFO_DATA = 14'h0003;
  localparam logic [13:0] ADDR_DROP_CNT  = 14'h0004;
  localparam logic [13:0] ADDR_THRESH    = 14'h0005;
  // Address the slave presents on a read/write collision; never decoded.
  localparam logic [13:0] ADDR_COLLISION = 14'h1ADE;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_TSCLR_BIT = 2;

  localparam int STATUS_COUNT_W   = 11;
  localparam int STATUS_EMPTY_BIT = 16;
  localparam int STATUS_FULL_BIT  = 17;
  localparam int STATUS_OVF_BIT   = 18;

  localparam logic [31:0] UNMAPPED_DATA = 32'hDEADBEEF;

  localparam int ENTRY_VALID_W = 1;
  localparam int ENTRY_ID_W    = 7;
  localparam int ENTRY_TS_W    = 24;
  localparam int ENTRY_W       = ENTRY_VALID_W + ENTRY_ID_W + ENTRY_TS_W;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [ENTRY_ID_W-1:0] id,
                                                    input logic [ENTRY_TS_W-1:0] ts);
    return {1'b1, id, ts};
  endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush; pointers carry one extra
// bit so full and empty are distinguishable.
module trace_sync_fifo
  import trace_regs_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;
  logic             full_s;
  logic             empty_s;

  // Status flags and qualified push/pop; a pop on a full FIFO frees the slot the push takes.
  always_comb begin
    empty_s   = (wr_ptr_r == rd_ptr_r);
    full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_pop_s  = pop & ~empty_s;
    do_push_s = push & (~full_s | do_pop_s);
  end

  // Pointer update; flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r[AW-1:0]];
  assign count = wr_ptr_r - rd_ptr_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/trace_event_regs.sv
// Trace event register block: timestamps monitor events into a FIFO drained via
// pop-on-read. Optional threshold interrupt and THRESH register under TRACE_IRQ_EN.
module trace_event_regs
  import trace_regs_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int TS_WIDTH   = 24
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [13:0] slv_reg_addr,
  input  logic        slv_reg_addr_vld,
  input  logic [31:0] slv_reg_out,
  input  logic        slv_reg_out_vld,
  output logic [31:0] slv_reg_in,
  output logic        slv_reg_in_vld,
  input  logic        evt_valid,
  input  logic [6:0]  evt_id,
  output logic        evt_ready,
  output logic        trace_irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              en_r;
  logic [31:0]       ts_r;
  logic              ovf_r;
  logic [31:0]       drop_cnt_r;

  logic              rd_s;
  logic              wr_s;
  logic              wr_ctrl_s;
  logic              wr_status_s;
  logic              wr_drop_s;
  logic              flush_s;
  logic              tsclr_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic [31:0]       entry_s;
  logic [31:0]       fifo_dout_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              full_s;
  logic              empty_s;
  logic [STATUS_COUNT_W-1:0] count_ext_s;
  logic [31:0]       status_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  assign unused_s = ^slv_reg_out[31:11];

  // Bus decode and event qualification; collision address never writes.
  always_comb begin
    rd_s        = slv_reg_addr_vld & ~slv_reg_out_vld;
    wr_s        = slv_reg_addr_vld & slv_reg_out_vld & (slv_reg_addr != ADDR_COLLISION);
    wr_ctrl_s   = wr_s & (slv_reg_addr == ADDR_CTRL);
    wr_status_s = wr_s & (slv_reg_addr == ADDR_STATUS);
    wr_drop_s   = wr_s & (slv_reg_addr == ADDR_DROP_CNT);
    flush_s     = wr_ctrl_s & slv_reg_out[CTRL_FLUSH_BIT];
    tsclr_s     = wr_ctrl_s & slv_reg_out[CTRL_TSCLR_BIT];
    pop_s       = rd_s & (slv_reg_addr == ADDR_FIFO_DATA) & ~empty_s;
    // A flush discards a coincident event outright, so it is neither pushed nor dropped.
    push_s      = en_r & evt_valid & ~flush_s;
    drop_s      = push_s & full_s & ~pop_s;
    entry_s     = make_entry(evt_id, ts_r[TS_WIDTH-1:0]);
  end

  trace_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .din   (entry_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // CTRL enable bit.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      en_r <= 1'b0;
    end else if (wr_ctrl_s) begin
      en_r <= slv_reg_out[CTRL_EN_BIT];
    end
  end

  // Free-running timestamp; clear wins over increment.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ts_r <= 32'd0;
    end else if (tsclr_s) begin
      ts_r <= 32'd0;
    end else if (en_r) begin
      ts_r <= ts_r + 32'd1;
    end
  end

  // Sticky overflow flag; a new drop takes precedence over a clearing write.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (wr_status_s) begin
      ovf_r <= 1'b0;
    end
  end

  // Saturating drop counter; clear coincident with a drop restarts at one.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      drop_cnt_r <= 32'd0;
    end else if (wr_drop_s && drop_s) begin
      drop_cnt_r <= 32'd1;
    end else if (wr_drop_s) begin
      drop_cnt_r <= 32'd0;
    end else if (drop_s && (drop_cnt_r != 32'hFFFF_FFFF)) begin
      drop_cnt_r <= drop_cnt_r + 32'd1;
    end
  end

`ifdef TRACE_IRQ_EN
  logic [STATUS_COUNT_W-1:0] thresh_r;
  logic                      irq_r;

  // THRESH register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      thresh_r <= 11'd0;
    end else if (wr_s && (slv_reg_addr == ADDR_THRESH)) begin
      thresh_r <= slv_reg_out[STATUS_COUNT_W-1:0];
    end
  end

  // Level interrupt, registered one cycle behind the fill-level condition.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= en_r & (thresh_r != 11'd0) & (count_ext_s >= thresh_r);
    end
  end

  assign trace_irq = irq_r;
`else
  assign trace_irq = 1'b0;
`endif

  // STATUS image with the FIFO count zero-extended to the 11-bit field.
  always_comb begin
    count_ext_s = 11'd0;
    count_ext_s[CNT_W-1:0] = fifo_count_s;
    status_s = 32'd0;
    status_s[STATUS_COUNT_W-1:0] = count_ext_s;
    status_s[STATUS_EMPTY_BIT]   = empty_s;
    status_s[STATUS_FULL_BIT]    = full_s;
    status_s[STATUS_OVF_BIT]     = ovf_r;
  end

  // Combinational read mux so the read handshake completes in the strobe cycle.
  always_comb begin
    rdata_s = 32'd0;
    if (rd_s) begin
      case (slv_reg_addr)
        ADDR_CTRL:      rdata_s = {31'd0, en_r};
        ADDR_STATUS:    rdata_s = status_s;
        ADDR_TIMESTAMP: rdata_s = ts_r;
        ADDR_FIFO_DATA: rdata_s = empty_s ? 32'd0 : fifo_dout_s;
        ADDR_DROP_CNT:  rdata_s = drop_cnt_r;
`ifdef TRACE_IRQ_EN
        ADDR_THRESH:    rdata_s = {21'd0, thresh_r};
`endif
        default:        rdata_s = UNMAPPED_DATA;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign slv_reg_in     = rdata_s;
  assign slv_reg_in_vld = rd_s;
  assign evt_ready      = en_r;

endmodule

// File: tb/tb_trace_event_regs.sv
// Self-checking bench for trace_event_regs: table of register accesses plus
// hand-written sequences for capture, overflow, flush, collisions, IRQ and reset.
module tb_trace_event_regs;

  logic        S_AXI_ACLK;
  logic        S_AXI_ARESETN;
  logic [13:0] slv_reg_addr;
  logic        slv_reg_addr_vld;
  logic [31:0] slv_reg_out;
  logic        slv_reg_out_vld;
  logic [31:0] slv_reg_in;
  logic        slv_reg_in_vld;
  logic        evt_valid;
  logic [6:0]  evt_id;
  logic        evt_ready;
  logic        trace_irq;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [13:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    logic [13:0] addr;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[13];

  trace_event_regs #(.FIFO_DEPTH(64), .TS_WIDTH(24)) dut (
    .S_AXI_ACLK       (S_AXI_ACLK),
    .S_AXI_ARESETN    (S_AXI_ARESETN),
    .slv_reg_addr     (slv_reg_addr),
    .slv_reg_addr_vld (slv_reg_addr_vld),
    .slv_reg_out      (slv_reg_out),
    .slv_reg_out_vld  (slv_reg_out_vld),
    .slv_reg_in       (slv_reg_in),
    .slv_reg_in_vld   (slv_reg_in_vld),
    .evt_valid        (evt_valid),
    .evt_id           (evt_id),
    .evt_ready        (evt_ready),
    .trace_irq        (trace_irq)
  );

  initial S_AXI_ACLK = 1'b0;
  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks start and end 1ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge S_AXI_ACLK);
      #1;
    end
  endtask

  task automatic bus_write(input logic [13:0] addr, input logic [31:0] data);
    slv_reg_addr = addr; slv_reg_out = data;
    slv_reg_addr_vld = 1'b1; slv_reg_out_vld = 1'b1;
    @(negedge S_AXI_ACLK);
    chk($sformatf("wr_vld_%h", addr), {31'd0, slv_reg_in_vld}, 32'd0);
    @(posedge S_AXI_ACLK); #1;
    slv_reg_addr_vld = 1'b0; slv_reg_out_vld = 1'b0;
  endtask

  task automatic bus_read(input logic [13:0] addr, input logic [31:0] exp, input logic [31:0] mask);
    exp_t e;
    slv_reg_addr = addr;
    slv_reg_addr_vld = 1'b1; slv_reg_out_vld = 1'b0;
    sb_q.push_back('{exp: exp, mask: mask, addr: addr});
    @(negedge S_AXI_ACLK);
    e = sb_q.pop_front();
    chk($sformatf("rd_vld_%h", e.addr), {31'd0, slv_reg_in_vld}, 32'd1);
    chk($sformatf("rd_%h", e.addr), slv_reg_in & e.mask, e.exp & e.mask);
    @(posedge S_AXI_ACLK); #1;
    slv_reg_addr_vld = 1'b0;
  endtask

  initial begin
    logic [6:0] id;
    S_AXI_ARESETN = 1'b0;
    slv_reg_addr = 14'd0; slv_reg_addr_vld = 1'b0;
    slv_reg_out = 32'd0; slv_reg_out_vld = 1'b0;
    evt_valid = 1'b0; evt_id = 7'd0;
    repeat (3) @(posedge S_AXI_ACLK);
    #1 S_AXI_ARESETN = 1'b1;
    chk("rst_irq", {31'd0, trace_irq}, 32'd0);
    chk("rst_ready", {31'd0, evt_ready}, 32'd0);
    chk("rst_in_vld", {31'd0, slv_reg_in_vld}, 32'd0);

    // Test 1: reset state and address map.
    vecs[0]  = '{addr: 14'h0001, wr: 1'b0, wdata: 32'd0, exp: 32'h0001_0000};
    vecs[1]  = '{addr: 14'h0003, wr: 1'b0, wdata: 32'd0, exp: 32'h0000_0000};
    vecs[2]  = '{addr: 14'h0007, wr: 1'b0, wdata: 32'd0, exp: 32'hDEAD_BEEF};
    vecs[3]  = '{addr: 14'h0000, wr: 1'b0, wdata: 32'd0, exp: 32'h0000_0000};
    vecs[4]  = '{addr: 14'h0002, wr: 1'b0, wdata: 32'd0, exp: 32'h0000_0000};
    vecs[5]  = '{addr: 14'h0004, wr: 1'b0, wdata: 32'd0, exp: 32'h0000_0000};
`ifdef TRACE_IRQ_EN
    vecs[6]  = '{addr: 14'h0005, wr: 1'b0, wdata: 32'd0, exp: 32'h0000_0000};
`else
    vecs[6]  = '{addr: 14'h0005, wr: 1'b0, wdata: 32'd0, exp: 32'hDEAD_BEEF};
`endif
    vecs[7]  = '{addr: 14'h1ADE, wr: 1'b0, wdata: 32'd0, exp: 32'hDEAD_BEEF};
    vecs[8]  = '{addr: 14'h1ADE, wr: 1'b1, wdata: 32'd7, exp: 32'd0};
    vecs[9]  = '{addr: 14'h0000, wr: 1'b0, wdata: 32'd0, exp: 32'h0000_0000};
    vecs[10] = '{addr: 14'h3FFF, wr: 1'b0, wdata: 32'd0, exp: 32'hDEAD_BEEF};
    vecs[11] = '{addr: 14'h0000, wr: 1'b1, wdata: 32'd6, exp: 32'd0};
    vecs[12] = '{addr: 14'h0000, wr: 1'b0, wdata: 32'd0, exp: 32'h0000_0000};
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      else            bus_read(vecs[i].addr, vecs[i].exp, 32'hFFFF_FFFF);
    end

    // Test 2: single event at timestamp 10.
    bus_write(14'h0, 32'd5);
    chk("ready_en", {31'd0, evt_ready}, 32'd1);
    idle(10);
    evt_valid = 1'b1; evt_id = 7'h05;
    idle(1);
    evt_valid = 1'b0;
    bus_read(14'h1, 32'h0000_0001, 32'hFFFF_FFFF);
    bus_read(14'h3, 32'h8500_000A, 32'hFFFF_FFFF);
    bus_read(14'h1, 32'h0001_0000, 32'hFFFF_FFFF);

    // Test 3: fill, overflow, clears.
    for (int i = 0; i < 67; i++) begin
      evt_valid = 1'b1; id = i[6:0]; evt_id = id;
      idle(1);
    end
    evt_valid = 1'b0;
    bus_read(14'h1, 32'h0006_0040, 32'hFFFF_FFFF);
    bus_read(14'h4, 32'd3, 32'hFFFF_FFFF);
    bus_write(14'h1, 32'd0);
    bus_read(14'h1, 32'h0002_0040, 32'hFFFF_FFFF);
    bus_write(14'h4, 32'd0);
    bus_read(14'h4, 32'd0, 32'hFFFF_FFFF);

    // Test 4: push and pop on a full FIFO.
    evt_valid = 1'b1; evt_id = 7'h7F;
    bus_read(14'h3, 32'h8000_0000, 32'hFF00_0000);
    evt_valid = 1'b0;
    bus_read(14'h1, 32'h0002_0040, 32'hFFFF_FFFF);
    for (int i = 1; i < 64; i++) begin
      id = i[6:0];
      bus_read(14'h3, {1'b1, id, 24'd0}, 32'hFF00_0000);
    end
    bus_read(14'h3, 32'hFF00_0000, 32'hFF00_0000);
    bus_read(14'h3, 32'h0000_0000, 32'hFFFF_FFFF);
    bus_read(14'h1, 32'h0001_0000, 32'hFFFF_FFFF);
    bus_read(14'h4, 32'd0, 32'hFFFF_FFFF);

    // Test 5: flush vs push, TSCLR, drop-clear collision, EN=0.
    evt_valid = 1'b1; evt_id = 7'h11;
    idle(65);
    bus_write(14'h0, 32'd3);
    evt_valid = 1'b0;
    bus_read(14'h1, 32'h0005_0000, 32'hFFFF_FFFF);
    bus_read(14'h4, 32'd1, 32'hFFFF_FFFF);
    bus_write(14'h0, 32'd5);
    bus_read(14'h2, 32'd0, 32'hFFFF_FFFC);
    evt_valid = 1'b1;
    idle(66);
    evt_valid = 1'b0;
    bus_read(14'h4, 32'd3, 32'hFFFF_FFFF);
    evt_valid = 1'b1;
    bus_write(14'h4, 32'd0);
    evt_valid = 1'b0;
    bus_read(14'h4, 32'd1, 32'hFFFF_FFFF);
    bus_write(14'h0, 32'd2);
    evt_valid = 1'b1;
    idle(3);
    evt_valid = 1'b0;
    chk("ready_dis", {31'd0, evt_ready}, 32'd0);
    bus_read(14'h1, 32'h0005_0000, 32'hFFFF_FFFF);
    bus_write(14'h1, 32'd0);
    bus_read(14'h1, 32'h0001_0000, 32'hFFFF_FFFF);

    // Test 6: threshold interrupt (or its absence).
    bus_write(14'h5, 32'd4);
`ifdef TRACE_IRQ_EN
    bus_read(14'h5, 32'd4, 32'hFFFF_FFFF);
`else
    bus_read(14'h5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
`endif
    bus_write(14'h0, 32'd1);
    evt_valid = 1'b1; evt_id = 7'h22;
    idle(4);
    evt_valid = 1'b0;
    chk("irq_4th_push", {31'd0, trace_irq}, 32'd0);
    idle(1);
`ifdef TRACE_IRQ_EN
    chk("irq_rise", {31'd0, trace_irq}, 32'd1);
    bus_read(14'h3, 32'hA200_0000, 32'hFF00_0000);
    chk("irq_hold", {31'd0, trace_irq}, 32'd1);
    idle(1);
    chk("irq_fall", {31'd0, trace_irq}, 32'd0);
`else
    chk("irq_tied", {31'd0, trace_irq}, 32'd0);
    bus_read(14'h3, 32'hA200_0000, 32'hFF00_0000);
`endif

    // Reset mid-burst.
    evt_valid = 1'b1;
    idle(3);
`ifdef TRACE_IRQ_EN
    chk("irq_pre_rst", {31'd0, trace_irq}, 32'd1);
`endif
    #1 S_AXI_ARESETN = 1'b0;
    #1;
    chk("rst_async_irq", {31'd0, trace_irq}, 32'd0);
    chk("rst_async_ready", {31'd0, evt_ready}, 32'd0);
    slv_reg_addr = 14'h1; slv_reg_addr_vld = 1'b1; slv_reg_out_vld = 1'b0;
    #1;
    chk("rst_async_status", slv_reg_in, 32'h0001_0000);
    slv_reg_addr_vld = 1'b0; evt_valid = 1'b0;
    @(posedge S_AXI_ACLK); #1;
    S_AXI_ARESETN = 1'b1;
    bus_read(14'h2, 32'd0, 32'hFFFF_FFFF);
    bus_read(14'h4, 32'd0, 32'hFFFF_FFFF);
    bus_read(14'h0, 32'd0, 32'hFFFF_FFFF);
    bus_read(14'h1, 32'h0001_0000, 32'hFFFF_FFFF);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
